// File: rtl/mgmt_sram_pkg.sv
// Shared constants and helpers for the banked management SRAM controller.
package mgmt_sram_pkg;

  // Port identifiers, used to specialise the per-port return path.
  localparam int PORT_CORE = 0;
  localparam int PORT_RO   = 1;

  // Default number of consecutive lost conflicts before the read-only port wins.
  localparam int STARVE_LIM_DEF = 4;

  // Ceiling log2 usable in parameter expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mgmt_sram_rdmux.sv
// Per-port return path: remembers which bank was granted last cycle and
// selects that bank's registered read data one cycle later.
module mgmt_sram_rdmux
  import mgmt_sram_pkg::*;
#(
  parameter int BANKS   = 4,
  parameter int SEL_W   = 2,
  parameter int PORT_ID = PORT_CORE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 gnt,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 is_rd,
  input  logic [32*BANKS-1:0]  bank_do,
  output logic                 ack,
  output logic [31:0]          data
);

  logic [SEL_W-1:0] sel_q;
  logic             pend_q;
  logic             is_rd_q;
  logic             rd;

  // The read-only port can only ever read, whatever its is_rd input says.
  assign rd = (PORT_ID == PORT_RO) ? 1'b1 : is_rd;

  // Capture the granted bank and access kind; the ack follows every grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= '0;
      pend_q  <= 1'b0;
      is_rd_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, so the order of these lines does not matter.
      pend_q <= gnt;
      if (gnt) begin
        sel_q   <= sel;
        is_rd_q <= rd;
      end
    end
  end

  assign ack = pend_q;

  // Select the granted bank's output; zero when idle or after a write.
  always_comb begin
    // NOTE: assigning the default first means every path writes data,
    // so no latch is inferred.
    data = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (pend_q && is_rd_q && (sel_q == SEL_W'(b))) begin
        data = bank_do[32*b +: 32];
      end
    end
  end

endmodule

// File: rtl/mgmt_sram_arbiter.sv
// Banked SRAM port controller: routes the management core port and the
// housekeeping read-only port onto single-port DFFRAM banks, granting both
// when they target different banks and arbitrating same-bank conflicts with
// core priority bounded by a starvation limit for the read-only port.
module mgmt_sram_arbiter
  import mgmt_sram_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int BANKS      = 4,
  parameter int STARVE_LIM = STARVE_LIM_DEF,
  localparam int BANK_AW   = ADDR_W - clog2(BANKS)
) (
  input  logic                      core_clk,
  input  logic                      core_rst,
  input  logic                      core_en,
  input  logic [3:0]                core_we,
  input  logic [ADDR_W-1:0]         core_addr,
  input  logic [31:0]               core_di,
  output logic                      core_gnt,
  output logic                      core_ack,
  output logic [31:0]               core_do,
  input  logic                      ro_en,
  input  logic [ADDR_W-1:0]         ro_addr,
  output logic                      ro_gnt,
  output logic                      ro_ack,
  output logic [31:0]               ro_data,
  output logic [BANKS-1:0]          bank_en,
  output logic [4*BANKS-1:0]        bank_we,
  output logic [BANK_AW*BANKS-1:0]  bank_a,
  output logic [32*BANKS-1:0]       bank_di,
  input  logic [32*BANKS-1:0]       bank_do
);

  // A single bank still needs a one-bit select to keep the ports legal.
  localparam int SEL_W = (BANKS > 1) ? clog2(BANKS) : 1;

  logic [SEL_W-1:0]   core_bank;
  logic [SEL_W-1:0]   ro_bank;
  logic [BANK_AW-1:0] core_off;
  logic [BANK_AW-1:0] ro_off;
  logic               same_bank;
  logic               starved;
  logic               ro_lose;
  logic [3:0]         starve_cnt;

  // Bank index is the top address bits, offset the low BANK_AW bits.
  assign core_bank = SEL_W'(core_addr >> BANK_AW);
  assign ro_bank   = SEL_W'(ro_addr >> BANK_AW);
  assign core_off  = core_addr[BANK_AW-1:0];
  assign ro_off    = ro_addr[BANK_AW-1:0];

  // Conflict only when both ports are requesting the same bank.
  assign same_bank = core_en && ro_en && (core_bank == ro_bank);
  assign starved   = (starve_cnt == 4'(STARVE_LIM));
  assign core_gnt  = core_en && !(same_bank && starved);
  assign ro_gnt    = ro_en && !(same_bank && !starved);
  assign ro_lose   = same_bank && !starved;

  // Count consecutive lost conflicts; a read-only grant restarts the count.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      starve_cnt <= 4'd0;
    end else if (ro_gnt) begin
      starve_cnt <= 4'd0;
    end else if (ro_lose && (starve_cnt < 4'(STARVE_LIM))) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Steer each granted request onto its bank; idle banks see all zeros.
  always_comb begin
    bank_en = '0;
    bank_we = '0;
    bank_a  = '0;
    bank_di = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (core_gnt && (core_bank == SEL_W'(b))) begin
        bank_en[b]                  = 1'b1;
        bank_we[4*b +: 4]           = core_we;
        bank_a[BANK_AW*b +: BANK_AW] = core_off;
        bank_di[32*b +: 32]         = core_di;
      end else if (ro_gnt && (ro_bank == SEL_W'(b))) begin
        bank_en[b]                  = 1'b1;
        bank_we[4*b +: 4]           = 4'b0000;
        bank_a[BANK_AW*b +: BANK_AW] = ro_off;
        bank_di[32*b +: 32]         = core_di;
      end
    end
  end

  mgmt_sram_rdmux #(
    .BANKS   (BANKS),
    .SEL_W   (SEL_W),
    .PORT_ID (PORT_CORE)
  ) u_core_rdmux (
    .clk     (core_clk),
    .rst     (core_rst),
    .gnt     (core_gnt),
    .sel     (core_bank),
    .is_rd   (core_we == 4'b0000),
    .bank_do (bank_do),
    .ack     (core_ack),
    .data    (core_do)
  );

  mgmt_sram_rdmux #(
    .BANKS   (BANKS),
    .SEL_W   (SEL_W),
    .PORT_ID (PORT_RO)
  ) u_ro_rdmux (
    .clk     (core_clk),
    .rst     (core_rst),
    .gnt     (ro_gnt),
    .sel     (ro_bank),
    .is_rd   (1'b1),
    .bank_do (bank_do),
    .ack     (ro_ack),
    .data    (ro_data)
  );

endmodule
